// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {remainder, quotient} 33 edges after acceptance. A zero divisor
// yields a zero result one edge after acceptance. Dropping start_i or
// raising annul_i aborts the operation, and no partial result is ever
// presented on result_o.
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BY_ZERO = 2'b01,
        ON      = 2'b10,
        END     = 2'b11
    } state_t;

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    // {partial remainder, dividend shift}. The 33rd remainder bit is always
    // zero between steps (remainder < divisor), so it is formed
    // combinationally inside the subtractor instead of being stored.
    logic [2*DATA_W-1:0]   work, work_n;
    logic [DATA_W-1:0]     divisor, divisor_n;
    logic                  sign_q, sign_q_n;
    logic                  sign_r, sign_r_n;
    logic [2*DATA_W-1:0]   result_n;
    logic                  ready_n;

    // Operand magnitudes and sign bookkeeping at acceptance.
    logic                  op1_neg, op2_neg;
    logic [DATA_W-1:0]     op1_mag, op2_mag;

    // One restoring step and the sign-corrected final result.
    logic [DATA_W:0]       minuend;
    logic [DATA_W:0]       diff;
    logic [2*DATA_W-1:0]   step_work;
    logic [DATA_W-1:0]     quo_raw, rem_raw;
    logic [DATA_W-1:0]     quo_fix, rem_fix;

    // Magnitudes of the incoming operands; a negative signed operand is
    // two's-complement negated, so 0x80000000 maps to its unsigned magnitude.
    always_comb begin
        op1_neg = signed_div_i & opdata1_i[DATA_W-1];
        op2_neg = signed_div_i & opdata2_i[DATA_W-1];
        op1_mag = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
        op2_mag = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
    end

    // Restoring step: shift the working register left, try the subtract in
    // DATA_W+1 bits, keep the difference and shift in 1 when non-negative.
    always_comb begin
        minuend   = work[2*DATA_W-1:DATA_W-1];
        diff      = minuend - {1'b0, divisor};
        step_work = diff[DATA_W]
                  ? {minuend[DATA_W-1:0], work[DATA_W-2:0], 1'b0}
                  : {diff[DATA_W-1:0],    work[DATA_W-2:0], 1'b1};
    end

    // Sign application: quotient takes sign1^sign2, remainder takes sign1.
    // Both flags are already cleared for unsigned operations.
    always_comb begin
        quo_raw = work[DATA_W-1:0];
        rem_raw = work[2*DATA_W-1:DATA_W];
        quo_fix = sign_q ? (~quo_raw + 1'b1) : quo_raw;
        rem_fix = sign_r ? (~rem_raw + 1'b1) : rem_raw;
    end

    // Next-state and next-output logic for the divider FSM.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        work_n    = work;
        divisor_n = divisor;
        sign_q_n  = sign_q;
        sign_r_n  = sign_r;
        result_n  = result_o;
        ready_n   = ready_o;

        unique case (state)
            IDLE: begin
                result_n = '0;
                ready_n  = 1'b0;
                cnt_n    = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = BY_ZERO;
                    end else begin
                        state_n   = ON;
                        work_n    = {{DATA_W{1'b0}}, op1_mag};
                        divisor_n = op2_mag;
                        sign_q_n  = op1_neg ^ op2_neg;
                        sign_r_n  = op1_neg;
                    end
                end
            end

            BY_ZERO: begin
                if (annul_i || !start_i) begin
                    state_n  = IDLE;
                    ready_n  = 1'b0;
                    result_n = '0;
                end else begin
                    state_n  = END;
                    ready_n  = 1'b1;
                    result_n = '0;
                end
            end

            ON: begin
                if (annul_i || !start_i) begin
                    state_n  = IDLE;
                    ready_n  = 1'b0;
                    result_n = '0;
                    cnt_n    = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n  = END;
                    ready_n  = 1'b1;
                    result_n = {rem_fix, quo_fix};
                end else begin
                    work_n = step_work;
                    cnt_n  = cnt + 1'b1;
                end
            end

            END: begin
                if (annul_i || !start_i) begin
                    state_n  = IDLE;
                    ready_n  = 1'b0;
                    result_n = '0;
                end
            end

            default: begin
                state_n  = IDLE;
                ready_n  = 1'b0;
                result_n = '0;
                cnt_n    = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            work     <= work_n;
            divisor  <= divisor_n;
            sign_q   <= sign_q_n;
            sign_r   <= sign_r_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int unsigned total  = 0;
    int unsigned passed = 0;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one operation with start held, scramble the operands after
    // acceptance, check ready timing and result, hold in END for 'hold'
    // extra cycles, then release start and check the return to idle.
    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int unsigned hold);
        logic early;
        logic stable;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        annul      = 1'b0;
        tick();                                  // edge 0: acceptance
        op1        = $urandom;
        op2        = $urandom;
        signed_div = ~sgn;
        early      = ready;
        for (int k = 1; k <= 32; k++) begin      // edges 1..32
            tick();
            early = early | ready;
        end
        chk({tag, " ready_early"}, {63'b0, early}, 64'd0);
        tick();                                  // edge 33
        chk({tag, " ready"}, {63'b0, ready}, 64'd1);
        chk({tag, " result"}, result, exp);
        if (hold > 0) begin
            stable = 1'b1;
            for (int unsigned h = 0; h < hold; h++) begin
                tick();
                if (ready !== 1'b1 || result !== exp) stable = 1'b0;
            end
            chk({tag, " hold_stable"}, {63'b0, stable}, 64'd1);
        end
        start = 1'b0;
        tick();
        chk({tag, " idle_ready"}, {63'b0, ready}, 64'd0);
        chk({tag, " idle_result"}, result, 64'd0);
    endtask

    // Start an operation and abort it at edge 10, via annul or start drop,
    // then confirm nothing ever escapes.
    task automatic abort_op(input string tag, input logic use_annul);
        logic leak;
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        annul      = 1'b0;
        tick();                                  // edge 0
        for (int k = 1; k <= 9; k++) tick();     // edges 1..9
        if (use_annul) annul = 1'b1;
        else           start = 1'b0;
        tick();                                  // edge 10: abort
        annul = 1'b0;
        start = 1'b0;
        chk({tag, " abort_ready"}, {63'b0, ready}, 64'd0);
        chk({tag, " abort_result"}, result, 64'd0);
        leak = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ready !== 1'b0 || result !== 64'd0) leak = 1'b1;
        end
        chk({tag, " no_leak"}, {63'b0, leak}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;
        tick();
        tick();
        chk("reset ready", {63'b0, ready}, 64'd0);
        chk("reset result", result, 64'd0);
        rst = 1'b0;
        tick();

        // Unsigned and signed sign combinations
        run_op("divu_100_7",   1'b0, 32'd100,      32'd7,        {32'h00000002, 32'h0000000E}, 0);
        run_op("div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}, 0);
        run_op("div_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 0);
        run_op("div_m7_m2",    1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'h00000003}, 0);
        run_op("divu_fff9_2",  1'b0, 32'hFFFFFFF9, 32'd2,        {32'h00000001, 32'h7FFFFFFC}, 0);

        // Divide by zero
        signed_div = 1'b1;
        op1        = 32'd5;
        op2        = 32'd0;
        start      = 1'b1;
        tick();                                  // edge 0
        chk("divz edge0 ready", {63'b0, ready}, 64'd0);
        tick();                                  // edge 1
        chk("divz ready", {63'b0, ready}, 64'd1);
        chk("divz result", result, 64'd0);
        start = 1'b0;
        tick();
        chk("divz idle ready", {63'b0, ready}, 64'd0);

        // Abort paths, each followed by a normal operation
        abort_op("annul", 1'b1);
        run_op("divu_ffff_10a", 1'b0, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF}, 0);
        abort_op("drop", 1'b0);
        run_op("divu_ffff_10b", 1'b0, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF}, 0);

        // Overflow wrap with hold in END; divisor 0x80000000 magnitude
        run_op("div_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 5);
        run_op("div_5_min",    1'b1, 32'd5,        32'h80000000, {32'h00000005, 32'h00000000}, 0);
        run_op("div_m5_min",   1'b1, 32'hFFFFFFFB, 32'h80000000, {32'hFFFFFFFB, 32'h00000000}, 0);
        run_op("div_min_min",  1'b1, 32'h80000000, 32'h80000000, {32'h00000000, 32'h00000001}, 0);

        // Reset at edge 20 of an operation
        signed_div = 1'b0;
        op1        = 32'd12345;
        op2        = 32'd67;
        start      = 1'b1;
        tick();                                  // edge 0
        for (int k = 1; k <= 19; k++) tick();    // edges 1..19
        rst = 1'b1;
        tick();                                  // edge 20
        chk("midrst ready", {63'b0, ready}, 64'd0);
        chk("midrst result", result, 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        run_op("post_rst", 1'b0, 32'd12345, 32'd67, {32'd17, 32'd184}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
